uio_bus_arbiter: RTL and testbench

- Shares the 8-bit bidirectional uio pin bank between two internal requesters (A, B).
- Each owner gets bursts of single-byte beats. Burst direction is fixed at grant: drive out, or sample in.
- Grants are round-robin. Idle turnaround cycles follow every driven burst so the pins never see drive contention.
- Sits between core logic and the top-level uio_out/uio_oe/uio_in pins.

---
 rtl/uio_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Purpose: shares the 8-bit uio pin bank between requesters A and B, one burst per grant.
// Latency: grant one cycle after a sampled request; ack is combinational; rvalid one cycle after a read beat.
// Backpressure: the owner throttles by dropping req (ends its burst); the non-owner waits for re-arbitration.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ena                    when low, IDLE issues no new grants (running bursts finish)
//   req_*/wr_*/wdata_*     per-requester request, direction (1 = drive pins) and write byte
//   gnt_*/ack_*/rvalid_*   per-requester ownership, beat completion, read data valid
//   rdata                  last captured read byte (shared)
//   uio_in/uio_out/uio_oe  pin bank
//   busy                   arbiter is not in IDLE
module uio_bus_arbiter #(
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req_a,
    input  logic       wr_a,
    input  logic [7:0] wdata_a,
    output logic       gnt_a,
    output logic       ack_a,
    output logic       rvalid_a,
    input  logic       req_b,
    input  logic       wr_b,
    input  logic [7:0] wdata_b,
    output logic       gnt_b,
    output logic       ack_b,
    output logic       rvalid_b,
    output logic [7:0] rdata,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [TW-1:0] tcnt_t;
    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;          // 0 = A, 1 = B
    logic   dir, dir_nxt;              // latched at grant, 1 = drive pins
    logic   last_owner, last_nxt;
    cnt_t   cnt, cnt_nxt;
    tcnt_t  tcnt, tcnt_nxt;

    logic   own_req;
    logic   beat;
    logic   win;
    state_t exit_st;

    assign own_req = owner ? req_b : req_a;
    assign beat    = (state == S_OWN) && own_req;
    // Contention goes to whoever did not own the bus last; otherwise the lone requester.
    assign win     = (req_a && req_b) ? ~last_owner : req_b;
    // Only a driven burst needs idle cycles before anyone else may drive.
    assign exit_st = (dir && (TURNAROUND > 0)) ? S_TURN : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            dir        <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            tcnt       <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            dir        <= dir_nxt;
            last_owner <= last_nxt;
            cnt        <= cnt_nxt;
            tcnt       <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        dir_nxt   = dir;
        last_nxt  = last_owner;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        case (state)
            S_IDLE: begin
                if (ena && (req_a || req_b)) begin
                    state_nxt = S_OWN;
                    owner_nxt = win;
                    dir_nxt   = win ? wr_b : wr_a;
                    last_nxt  = win;
                    cnt_nxt   = '0;
                end
            end
            S_OWN: begin
                if (!own_req) begin
                    state_nxt = exit_st;
                    tcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + cnt_t'(1);
                    if (cnt == cnt_t'(MAX_BURST - 1)) begin
                        state_nxt = exit_st;
                        tcnt_nxt  = '0;
                    end
                end
            end
            S_TURN: begin
                if (tcnt == tcnt_t'(TURNAROUND - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    tcnt_nxt = tcnt + tcnt_t'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read capture: the byte on the pins at the edge closing a read beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= beat && !dir && !owner;
            rvalid_b <= beat && !dir &&  owner;
            if (beat && !dir) begin
                rdata <= uio_in;
            end
        end
    end

    // Pin-facing outputs depend on registered state only (plus owner wdata).
    always_comb begin
        gnt_a   = (state == S_OWN) && !owner;
        gnt_b   = (state == S_OWN) &&  owner;
        ack_a   = beat && !owner;
        ack_b   = beat &&  owner;
        busy    = (state != S_IDLE);
        uio_oe  = 8'h00;
        uio_out = 8'h00;
        if ((state == S_OWN) && dir) begin
            uio_oe  = 8'hFF;
            uio_out = owner ? wdata_b : wdata_a;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
module tb_uio_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
    logic [7:0] wdata_a = 8'h00, wdata_b = 8'h00, uio_in = 8'h00;
    logic       gnt_a, ack_a, rvalid_a, gnt_b, ack_b, rvalid_b, busy;
    logic [7:0] rdata, uio_out, uio_oe;

    int total = 0;
    int bad   = 0;

    uio_bus_arbiter #(.TURNAROUND(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_a(req_a), .wr_a(wr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .ack_a(ack_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .wr_b(wr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .ack_b(ack_b), .rvalid_b(rvalid_b),
        .rdata(rdata), .uio_in(uio_in), .uio_out(uio_out),
        .uio_oe(uio_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ena, ra, wa;
        logic [7:0] da;
        logic       rb, wb;
        logic [7:0] db, uin;
    } in_t;

    typedef struct packed {
        logic       ga, gb, aa, ab, va, vb, busy;
        logic [7:0] oe, out, rd;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t vin(logic e, logic ra, logic wa, logic [7:0] da,
                                logic rb, logic wb, logic [7:0] db, logic [7:0] uin);
        in_t v;
        v.ena = e; v.ra = ra; v.wa = wa; v.da = da;
        v.rb = rb; v.wb = wb; v.db = db; v.uin = uin;
        return v;
    endfunction

    function automatic out_t vout(logic ga, logic gb, logic aa, logic ab, logic va, logic vb,
                                  logic bz, logic [7:0] oe, logic [7:0] out, logic [7:0] rd);
        out_t v;
        v.ga = ga; v.gb = gb; v.aa = aa; v.ab = ab; v.va = va; v.vb = vb;
        v.busy = bz; v.oe = oe; v.out = out; v.rd = rd;
        return v;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endtask

    function automatic out_t sample();
        return vout(gnt_a, gnt_b, ack_a, ack_b, rvalid_a, rvalid_b, busy, uio_oe, uio_out, rdata);
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input in_t i);
        ena = i.ena; req_a = i.ra; wr_a = i.wa; wdata_a = i.da;
        req_b = i.rb; wr_b = i.wb; wdata_b = i.db; uio_in = i.uin;
    endtask

    // Mutual exclusion and no ack without ownership, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((gnt_a && gnt_b) || (ack_a && !gnt_a) || (ack_b && !gnt_b)) begin
                bad++;
                $display("FAIL exclusive got gnt=%b%b ack=%b%b want no overlap", gnt_a, gnt_b, ack_a, ack_b);
            end
        end
    end

    initial begin
        in_t i3;
        out_t z;
        z = '0;

        // A writes 0x5A: four beats, one turnaround, one idle, re-grant, then drop.
        add(vin(1,1,1,8'h5A,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h00));
        for (int k = 0; k < 4; k++)
            add(vin(1,1,1,8'h5A,0,0,8'h00,8'h00), vout(1,0,1,0,0,0,1,8'hFF,8'h5A,8'h00));
        add(vin(1,1,1,8'h5A,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,1,8'h00,8'h00,8'h00));
        add(vin(1,1,1,8'h5A,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h00));
        add(vin(1,1,1,8'h5A,0,0,8'h00,8'h00), vout(1,0,1,0,0,0,1,8'hFF,8'h5A,8'h00));
        add(vin(1,0,1,8'h5A,0,0,8'h00,8'h00), vout(1,0,0,0,0,0,1,8'hFF,8'h5A,8'h00));
        add(vin(1,0,1,8'h5A,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,1,8'h00,8'h00,8'h00));
        add(vin(1,0,1,8'h5A,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h00));

        // B reads 0x3C: rvalid trails each ack, no turnaround afterwards.
        add(vin(1,0,0,8'h00,1,0,8'h00,8'h3C), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h00));
        add(vin(1,0,0,8'h00,1,0,8'h00,8'h3C), vout(0,1,0,1,0,0,1,8'h00,8'h00,8'h00));
        for (int k = 0; k < 3; k++)
            add(vin(1,0,0,8'h00,1,0,8'h00,8'h3C), vout(0,1,0,1,0,1,1,8'h00,8'h00,8'h3C));
        add(vin(1,0,0,8'h00,0,0,8'h00,8'h3C), vout(0,0,0,0,0,1,0,8'h00,8'h00,8'h3C));
        add(vin(1,0,0,8'h00,0,0,8'h00,8'h3C), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));

        // Both write continuously: A, B, A with two pin-idle cycles between bursts.
        i3 = vin(1,1,1,8'hA1,1,1,8'hB2,8'h00);
        add(i3, vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));
        for (int k = 0; k < 4; k++)
            add(i3, vout(1,0,1,0,0,0,1,8'hFF,8'hA1,8'h3C));
        add(i3, vout(0,0,0,0,0,0,1,8'h00,8'h00,8'h3C));
        add(i3, vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));
        for (int k = 0; k < 4; k++)
            add(i3, vout(0,1,0,1,0,0,1,8'hFF,8'hB2,8'h3C));
        add(i3, vout(0,0,0,0,0,0,1,8'h00,8'h00,8'h3C));
        add(i3, vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));
        add(i3, vout(1,0,1,0,0,0,1,8'hFF,8'hA1,8'h3C));
        add(vin(1,0,1,8'hA1,0,1,8'hB2,8'h00), vout(1,0,0,0,0,0,1,8'hFF,8'hA1,8'h3C));
        add(vin(1,0,1,8'hA1,0,1,8'hB2,8'h00), vout(0,0,0,0,0,0,1,8'h00,8'h00,8'h3C));
        add(vin(1,0,1,8'hA1,0,1,8'hB2,8'h00), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));

        // ena low holds IDLE; grant the cycle after ena rises; single read beat.
        add(vin(0,1,0,8'h00,0,0,8'h00,8'h77), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));
        add(vin(0,1,0,8'h00,0,0,8'h00,8'h77), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));
        add(vin(1,1,0,8'h00,0,0,8'h00,8'h77), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h3C));
        add(vin(1,1,0,8'h00,0,0,8'h00,8'h77), vout(1,0,1,0,0,0,1,8'h00,8'h00,8'h3C));
        add(vin(1,0,0,8'h00,0,0,8'h00,8'h77), vout(1,0,0,0,1,0,1,8'h00,8'h00,8'h77));
        add(vin(1,0,0,8'h00,0,0,8'h00,8'h77), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h77));

        // Two write beats with wr_a toggling, then drop: direction stays latched.
        add(vin(1,1,1,8'h66,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h77));
        add(vin(1,1,0,8'h66,0,0,8'h00,8'h00), vout(1,0,1,0,0,0,1,8'hFF,8'h66,8'h77));
        add(vin(1,1,1,8'h66,0,0,8'h00,8'h00), vout(1,0,1,0,0,0,1,8'hFF,8'h66,8'h77));
        add(vin(1,0,1,8'h66,0,0,8'h00,8'h00), vout(1,0,0,0,0,0,1,8'hFF,8'h66,8'h77));
        add(vin(1,0,1,8'h66,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,1,8'h00,8'h00,8'h77));
        add(vin(1,0,0,8'h66,0,0,8'h00,8'h00), vout(0,0,0,0,0,0,0,8'h00,8'h00,8'h77));

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", sample(), z);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            @(posedge clk);
            #1;
            drive(tbl[n].i);
            @(negedge clk);
            check($sformatf("row%0d", n), sample(), tbl[n].o);
        end

        // Asynchronous reset in the middle of A's second write beat.
        @(posedge clk);
        #1;
        drive(vin(1,1,1,8'h99,0,0,8'h00,8'h00));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_beat1", sample(), vout(1,0,1,0,0,0,1,8'hFF,8'h99,8'h77));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", sample(), z);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", sample(), z);
        drive(vin(1,1,1,8'h99,1,0,8'h00,8'h00));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_wins", sample(), vout(1,0,1,0,0,0,1,8'hFF,8'h99,8'h00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
